mc_control_unit: RTL and testbench
==================================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameters SHALL be: OPW, default 4, opcode width (>=4); ALUW, default 3, alu_control width; NUM_ALU_OPS, default 4, opcodes 0..NUM_ALU_OPS-1 are ALU ops (<=2^ALUW); CNTW, default 16, retired-instruction counter width.
REQ-002 One clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock; reset_n  in  1  asynchronous active-low reset.
REQ-003 Inputs SHALL be: opcode  in  OPW  IR opcode field; zero  in  1  accumulator-zero flag; mem_ready  in  1  memory completes the current access this cycle; resume  in  1  leave HALT.
REQ-004 Strobe outputs SHALL be: pc_write, pc_sel (0=PC address, 1=operand address), jump (PC loads branch target), res_sel (1=memory data to AC), mem_req, mem_write, ir_write, ac_write, b_write, o_write; each  out  1.
REQ-005 Other outputs SHALL be: alu_control  out  ALUW  ALU operation; state  out  3  encoded state; halted  out  1  in HALT; illegal  out  1  one-cycle undefined-opcode pulse; retired  out  CNTW  completed-instruction count.

Function
REQ-006 States SHALL be FETCH=0, DECODE=1, EXEC=2, WB=3, HALT=4; state output equals current encoding.
REQ-007 Opcode map SHALL be: ALU 0..NUM_ALU_OPS-1, JMP=8, JZ=9, OUT=10, LDA=12, LDB=13, STA=14, HLT=all-ones; all values zero-extended to OPW; anything else is undefined.
REQ-008 All strobes SHALL default to 0 and alu_control to 0 in every state unless stated.
REQ-009 FETCH SHALL assert mem_req, pc_sel=0; ir_write=1 only in a cycle with mem_ready=1, which moves to DECODE; otherwise FETCH holds.
REQ-010 DECODE SHALL assert pc_write for exactly one cycle; next state HALT if opcode=HLT, else EXEC.
REQ-011 EXEC, ALU op: alu_control=opcode[ALUW-1:0]; next WB.
REQ-012 EXEC, LDA/LDB: mem_req=1, pc_sel=1; LDA also res_sel=1; ac_write (LDA) or b_write (LDB) asserted only in the mem_ready=1 cycle, which moves to FETCH; otherwise EXEC holds.
REQ-013 EXEC, STA: mem_req=1, mem_write=1, pc_sel=1 held until mem_ready=1; then FETCH.
REQ-014 EXEC, OUT: o_write=1 one cycle; next FETCH.
REQ-015 EXEC, JMP: pc_write=1, jump=1 one cycle; JZ: same only if zero=1, else no strobes; next FETCH.
REQ-016 EXEC, undefined opcode: no strobes, illegal=1 one cycle; next FETCH; not counted as retired.
REQ-017 WB SHALL assert ac_write=1, res_sel=0, alu_control still equal to the ALU op; next FETCH.
REQ-018 HALT SHALL drive all strobes 0, halted=1; resume=1 moves to FETCH next cycle; resume outside HALT is ignored.
REQ-019 mem_ready SHALL be ignored in any cycle where mem_req=0.
REQ-020 retired SHALL increment by 1 on each transition EXEC->FETCH (except undefined), WB->FETCH, and DECODE->HALT; wraps 2^CNTW-1 -> 0.
REQ-021 Instruction latency with mem_ready always 1: ALU 4 cycles, LDA/LDB/STA/OUT/JMP/JZ 3 cycles.

Reset
REQ-022 reset_n=0 SHALL immediately, without clock, force state FETCH, retired=0, halted=0, illegal=0 and all strobes 0 except the FETCH Moore outputs (mem_req=1, pc_sel=0), including mid-wait or in HALT.
REQ-023 First rising edge after reset_n deasserts SHALL evaluate FETCH normally.

Structure
REQ-024 A shared package mcu_pkg SHALL hold the state enum and opcode constants; parameters stay on the module.
REQ-025 Implementation SHALL be a single module (state register, next-state logic, output decode, counter); no sub-module.

Verification
REQ-026 ADD (opcode 0), mem_ready=1: states 0,1,2,3,0; WB ac_write=1 alu_control=0; retired 0->1.
REQ-027 LDA (12) with mem_ready low 3 EXEC cycles: EXEC held 4 cycles, ac_write+res_sel only in 4th; mem_write never 1.
REQ-028 JZ (9) with zero=0 then zero=1: first no pc_write in EXEC, second pc_write=jump=1; retired +2.
REQ-029 HLT (15): DECODE->HALT, halted=1, retired +1, strobes 0 for 10 cycles; resume=1 -> FETCH next cycle.
REQ-030 Undefined opcode 11: illegal=1 one cycle, retired unchanged; reset_n pulsed low mid-STA wait -> state 0, mem_write=0 asynchronously.
REQ-031 CNTW=4: 16 retired instructions wrap retired 15->0.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared definitions for the multicycle control unit: state encoding,
// opcode map and an opcode classifier used by the EXEC decode.
package mcu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_JMP, K_JZ, K_OUT, K_LDA, K_LDB, K_STA, K_UNDEF
  } op_kind_t;

  localparam int unsigned OP_JMP = 8;
  localparam int unsigned OP_JZ  = 9;
  localparam int unsigned OP_OUT = 10;
  localparam int unsigned OP_LDA = 12;
  localparam int unsigned OP_LDB = 13;
  localparam int unsigned OP_STA = 14;

  // ALU range is checked first so the fixed opcodes never shadow it.
  function automatic op_kind_t classify(input int unsigned op,
                                        input int unsigned num_alu_ops);
    if (op < num_alu_ops) return K_ALU;
    case (op)
      OP_JMP:  return K_JMP;
      OP_JZ:   return K_JZ;
      OP_OUT:  return K_OUT;
      OP_LDA:  return K_LDA;
      OP_LDB:  return K_LDB;
      OP_STA:  return K_STA;
      default: return K_UNDEF;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_unit.sv
// Multicycle accumulator-machine control unit: FETCH/DECODE/EXEC/WB/HALT
// sequencer with decoded datapath strobes and a retired-instruction counter.
module mc_control_unit
  import mcu_pkg::*;
#(
  parameter int OPW         = 4,
  parameter int ALUW        = 3,
  parameter int NUM_ALU_OPS = 4,
  parameter int CNTW        = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            mem_ready,
  input  logic            resume,
  output logic            pc_write,
  output logic            pc_sel,
  output logic            jump,
  output logic            res_sel,
  output logic            mem_req,
  output logic            mem_write,
  output logic            ir_write,
  output logic            ac_write,
  output logic            b_write,
  output logic            o_write,
  output logic [ALUW-1:0] alu_control,
  output logic [2:0]      state,
  output logic            halted,
  output logic            illegal,
  output logic [CNTW-1:0] retired
);

  state_t          r_state;
  state_t          w_next;
  logic            w_retire;
  op_kind_t        w_kind;
  logic [CNTW-1:0] r_retired;

  assign w_kind  = classify(32'(opcode), 32'(NUM_ALU_OPS));
  assign state   = r_state;
  assign retired = r_retired;

  // NOTE: outputs are decoded from the state register rather than registered,
  // so an asynchronous reset shows the FETCH outputs at once and mem_ready can
  // qualify the write strobes within the same cycle.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    pc_write    = 1'b0;
    pc_sel      = 1'b0;
    jump        = 1'b0;
    res_sel     = 1'b0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    ac_write    = 1'b0;
    b_write     = 1'b0;
    o_write     = 1'b0;
    alu_control = '0;
    halted      = 1'b0;
    illegal     = 1'b0;
    w_retire    = 1'b0;
    w_next      = r_state;
    case (r_state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        pc_write = 1'b1;
        if (opcode == {OPW{1'b1}}) begin
          w_next   = S_HALT;
          w_retire = 1'b1;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
        case (w_kind)
          K_ALU: begin
            alu_control = ALUW'(opcode);
            w_next      = S_WB;
            w_retire    = 1'b0;
          end
          K_LDA, K_LDB: begin
            mem_req  = 1'b1;
            pc_sel   = 1'b1;
            res_sel  = (w_kind == K_LDA);
            ac_write = (w_kind == K_LDA) && mem_ready;
            b_write  = (w_kind == K_LDB) && mem_ready;
            if (!mem_ready) begin
              w_next   = S_EXEC;
              w_retire = 1'b0;
            end
          end
          K_STA: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            pc_sel    = 1'b1;
            if (!mem_ready) begin
              w_next   = S_EXEC;
              w_retire = 1'b0;
            end
          end
          K_OUT: o_write = 1'b1;
          K_JMP: begin
            pc_write = 1'b1;
            jump     = 1'b1;
          end
          K_JZ: begin
            pc_write = zero;
            jump     = zero;
          end
          default: begin
            illegal  = 1'b1;
            w_retire = 1'b0;
          end
        endcase
      end
      S_WB: begin
        ac_write    = 1'b1;
        alu_control = ALUW'(opcode);
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // NOTE: state and counter use non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed self-checking bench for mc_control_unit (counter narrowed to 4 bits
// so the wrap is reachable quickly).
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] opcode;
  logic       zero, mem_ready, resume;
  logic       pc_write, pc_sel, jump, res_sel, mem_req, mem_write;
  logic       ir_write, ac_write, b_write, o_write;
  logic [2:0] alu_control;
  logic [2:0] state;
  logic       halted, illegal;
  logic [3:0] retired;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_ret = '0;

  // {pc_write,pc_sel,jump,res_sel,mem_req,mem_write,ir_write,ac_write,b_write,o_write}
  logic [9:0] strb;
  assign strb = {pc_write, pc_sel, jump, res_sel, mem_req, mem_write,
                 ir_write, ac_write, b_write, o_write};

  localparam logic [9:0] ST_NONE  = 10'b00_0000_0000;
  localparam logic [9:0] ST_FWAIT = 10'b00_0010_0000;
  localparam logic [9:0] ST_FRDY  = 10'b00_0010_1000;
  localparam logic [9:0] ST_DEC   = 10'b10_0000_0000;
  localparam logic [9:0] ST_WB    = 10'b00_0000_0100;
  localparam logic [9:0] ST_LDAW  = 10'b01_0110_0000;
  localparam logic [9:0] ST_LDAR  = 10'b01_0110_0100;
  localparam logic [9:0] ST_LDBR  = 10'b01_0010_0010;
  localparam logic [9:0] ST_STA   = 10'b01_0011_0000;
  localparam logic [9:0] ST_OUT   = 10'b00_0000_0001;
  localparam logic [9:0] ST_JUMP  = 10'b10_1000_0000;

  mc_control_unit #(.OPW(4), .ALUW(3), .NUM_ALU_OPS(4), .CNTW(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .resume(resume),
    .pc_write(pc_write), .pc_sel(pc_sel), .jump(jump), .res_sel(res_sel),
    .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write),
    .ac_write(ac_write), .b_write(b_write), .o_write(o_write),
    .alu_control(alu_control), .state(state), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: present the opcode with memory ready and advance to EXEC.
  task automatic go_exec(input logic [3:0] op, input logic z);
    opcode = op; zero = z; mem_ready = 1'b1; resume = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    #12;
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", state); end
    n_checks++;
    if (strb !== ST_FWAIT) begin n_fail++; $display("FAIL reset_strobes: got %b exp %b", strb, ST_FWAIT); end
    n_checks++;
    if ({halted, illegal, retired} !== 6'd0) begin
      n_fail++; $display("FAIL reset_flags: got halted=%b illegal=%b retired=%0d exp 0", halted, illegal, retired);
    end
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL fetch_hold: got %0d exp 0", state); end
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 16; i++) begin
      go_exec(4'd10, 1'b0);
      tick();
      exp_ret = exp_ret + 4'd1;
      if (i == 15) begin
        n_checks++;
        if (retired !== 4'd15) begin n_fail++; $display("FAIL wrap_pre: got %0d exp 15", retired); end
      end
    end
    n_checks++;
    if (retired !== 4'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d exp 0", retired); end
  endtask

  task automatic test_alu(input logic [3:0] op);
    logic [2:0] exp_states [5];
    logic [9:0] exp_strb [5];
    exp_states = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    exp_strb   = '{ST_FRDY, ST_DEC, ST_NONE, ST_WB, ST_FRDY};
    opcode = op; mem_ready = 1'b1; zero = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (state !== exp_states[c] || strb !== exp_strb[c]) begin
        n_fail++;
        $display("FAIL alu%0d_cycle%0d: got state=%0d strb=%b exp state=%0d strb=%b",
                 op, c, state, strb, exp_states[c], exp_strb[c]);
      end
      if (c == 2 || c == 3) begin
        n_checks++;
        if (alu_control !== op[2:0]) begin
          n_fail++; $display("FAIL alu%0d_ctrl%0d: got %0d exp %0d", op, c, alu_control, op[2:0]);
        end
      end
      if (c < 4) tick();
    end
    exp_ret = exp_ret + 4'd1;
    n_checks++;
    if (retired !== exp_ret) begin n_fail++; $display("FAIL alu%0d_retired: got %0d exp %0d", op, retired, exp_ret); end
  endtask

  task automatic test_lda();
    go_exec(4'd12, 1'b0);
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (state !== 3'd2 || strb !== ST_LDAW) begin
        n_fail++; $display("FAIL lda_wait%0d: got state=%0d strb=%b exp 2 %b", c, state, strb, ST_LDAW);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd2 || strb !== ST_LDAR) begin
      n_fail++; $display("FAIL lda_ready: got state=%0d strb=%b exp 2 %b", state, strb, ST_LDAR);
    end
    tick();
    exp_ret = exp_ret + 4'd1;
    n_checks++;
    if (state !== 3'd0 || retired !== exp_ret) begin
      n_fail++; $display("FAIL lda_done: got state=%0d retired=%0d exp 0 %0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_ldb_sta();
    go_exec(4'd13, 1'b0);
    n_checks++;
    if (strb !== ST_LDBR) begin n_fail++; $display("FAIL ldb_strobes: got %b exp %b", strb, ST_LDBR); end
    tick();
    exp_ret = exp_ret + 4'd1;
    go_exec(4'd14, 1'b0);
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (strb !== ST_STA) begin n_fail++; $display("FAIL sta_wait: got %b exp %b", strb, ST_STA); end
    tick();
    n_checks++;
    if (state !== 3'd2) begin n_fail++; $display("FAIL sta_hold: got %0d exp 2", state); end
    mem_ready = 1'b1;
    tick();
    exp_ret = exp_ret + 4'd1;
    n_checks++;
    if (state !== 3'd0 || retired !== exp_ret) begin
      n_fail++; $display("FAIL sta_done: got state=%0d retired=%0d exp 0 %0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_branch();
    go_exec(4'd10, 1'b0);
    n_checks++;
    if (strb !== ST_OUT) begin n_fail++; $display("FAIL out_strobes: got %b exp %b", strb, ST_OUT); end
    tick();
    go_exec(4'd8, 1'b0);
    n_checks++;
    if (strb !== ST_JUMP) begin n_fail++; $display("FAIL jmp_strobes: got %b exp %b", strb, ST_JUMP); end
    tick();
    go_exec(4'd9, 1'b0);
    n_checks++;
    if (strb !== ST_NONE) begin n_fail++; $display("FAIL jz_not_taken: got %b exp %b", strb, ST_NONE); end
    tick();
    go_exec(4'd9, 1'b1);
    n_checks++;
    if (strb !== ST_JUMP) begin n_fail++; $display("FAIL jz_taken: got %b exp %b", strb, ST_JUMP); end
    tick();
    exp_ret = exp_ret + 4'd4;
    n_checks++;
    if (state !== 3'd0 || retired !== exp_ret) begin
      n_fail++; $display("FAIL branch_retired: got state=%0d retired=%0d exp 0 %0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_illegal();
    go_exec(4'd11, 1'b0);
    n_checks++;
    if (illegal !== 1'b1 || strb !== ST_NONE) begin
      n_fail++; $display("FAIL illegal_pulse: got illegal=%b strb=%b exp 1 %b", illegal, strb, ST_NONE);
    end
    tick();
    n_checks++;
    if (state !== 3'd0 || illegal !== 1'b0 || retired !== exp_ret) begin
      n_fail++; $display("FAIL illegal_after: got state=%0d illegal=%b retired=%0d exp 0 0 %0d",
                         state, illegal, retired, exp_ret);
    end
  endtask

  task automatic test_halt();
    opcode = 4'd15; mem_ready = 1'b1; resume = 1'b0;
    tick();
    n_checks++;
    if (state !== 3'd1 || strb !== ST_DEC) begin
      n_fail++; $display("FAIL hlt_decode: got state=%0d strb=%b exp 1 %b", state, strb, ST_DEC);
    end
    tick();
    exp_ret = exp_ret + 4'd1;
    n_checks++;
    if (halted !== 1'b1 || retired !== exp_ret) begin
      n_fail++; $display("FAIL hlt_enter: got halted=%b retired=%0d exp 1 %0d", halted, retired, exp_ret);
    end
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (state !== 3'd4 || strb !== ST_NONE || halted !== 1'b1) begin
        n_fail++; $display("FAIL hlt_idle%0d: got state=%0d strb=%b halted=%b exp 4 %b 1",
                           c, state, strb, halted, ST_NONE);
      end
      tick();
    end
    resume = 1'b1;
    tick();
    resume = 1'b1; mem_ready = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL hlt_resume: got state=%0d halted=%b exp 0 0", state, halted);
    end
    tick();
    resume = 1'b0;
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL resume_ignored: got %0d exp 0", state); end
  endtask

  task automatic test_reset_mid_sta();
    go_exec(4'd14, 1'b0);
    mem_ready = 1'b0;
    tick();
    n_checks++;
    if (mem_write !== 1'b1) begin n_fail++; $display("FAIL sta_pre_reset: got mem_write=%b exp 1", mem_write); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0 || strb !== ST_FWAIT || retired !== 4'd0) begin
      n_fail++; $display("FAIL async_reset: got state=%0d strb=%b retired=%0d exp 0 %b 0",
                         state, strb, retired, ST_FWAIT);
    end
    tick();
    reset_n = 1'b1;
    exp_ret = '0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_alu(4'd0);
    test_alu(4'd2);
    test_lda();
    test_ldb_sta();
    test_branch();
    test_illegal();
    test_halt();
    test_reset_mid_sta();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
